// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencer for the five-stage core. Drives the
//                capture/hold/bubble controls of every pipeline latch from
//                cache hits, load-use hazards, MEM-stage redirects and halt,
//                and keeps saturating stall/flush counters for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dreq,
   input  logic             mem_redirect,
   input  logic             ex_load,
   input  logic [4:0]       ex_rdest,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_clr,
   output logic             idex_clr,
   output logic             exmem_clr,
   output logic             memwb_clr,
   output logic             halt_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]       c_ST_RUN   = 2'b00;
   localparam logic [1:0]       c_ST_DWAIT = 2'b01;
   localparam logic [1:0]       c_ST_HALT  = 2'b10;
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_lu;
   logic             w_wait_miss;
   logic             w_redirect_taken;

   // Load-use: the ID instruction reads a register the EX load has not produced yet
   assign w_lu = ex_load && (ex_rdest != 5'd0) &&
                 ((ex_rdest == id_rs) || (id_uses_rt && (ex_rdest == id_rt)));

   // A pending data miss keeps DWAIT in the miss case regardless of other inputs
   assign w_wait_miss = (r_state == c_ST_DWAIT) && !dhit;

   // State register; reset drops any stall or halt straight back to RUN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= c_ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: HALT is terminal, misses park in DWAIT until dhit
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_HALT: w_next_state = c_ST_HALT;
         default: begin
            if (w_wait_miss)
               w_next_state = c_ST_DWAIT;
            else if (wb_halt)
               w_next_state = c_ST_HALT;
            else if (mem_dreq && !dhit)
               w_next_state = c_ST_DWAIT;
            else
               w_next_state = c_ST_RUN;
         end
      endcase
   end

   // Latch controls; a DWAIT cycle with dhit behaves exactly like RUN
   always_comb begin
      pc_en            = 1'b0;
      ifid_en          = 1'b0;
      idex_en          = 1'b0;
      exmem_en         = 1'b0;
      memwb_en         = 1'b0;
      ifid_clr         = 1'b0;
      idex_clr         = 1'b0;
      exmem_clr        = 1'b0;
      memwb_clr        = 1'b0;
      w_redirect_taken = 1'b0;
      if (!RST && (r_state != c_ST_HALT)) begin
         if (w_wait_miss) begin
            memwb_clr = 1'b1;
         end else if (wb_halt) begin
            // freeze everything while halt drains into HALT
         end else if (mem_dreq && !dhit) begin
            memwb_clr = 1'b1;
         end else if (mem_redirect) begin
            pc_en            = 1'b1;
            ifid_clr         = 1'b1;
            idex_clr         = 1'b1;
            exmem_clr        = 1'b1;
            memwb_en         = 1'b1;
            w_redirect_taken = 1'b1;
         end else if (w_lu) begin
            idex_clr = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end else if (!ihit) begin
            ifid_clr = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

   // Saturating debug counters, frozen once halted
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state != c_ST_HALT) begin
         if (!pc_en && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         if (w_redirect_taken && !(&r_flush_cnt))
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
   end

   assign halt_o    = (r_state == c_ST_HALT);
   assign state_o   = r_state;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl. A second
//                instance with 4-bit counters exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic        CLK;
   logic        RST;
   logic        ihit, dhit, mem_dreq, mem_redirect, ex_load, id_uses_rt, wb_halt;
   logic [4:0]  ex_rdest, id_rs, id_rt;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
   logic        halt_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic        s_ifid_clr, s_idex_clr, s_exmem_clr, s_memwb_clr;
   logic        s_halt_o;
   logic [1:0]  s_state_o;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   hazard_ctrl #(.CNT_W(16)) u_dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
      .mem_redirect(mem_redirect), .ex_load(ex_load), .ex_rdest(ex_rdest),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .wb_halt(wb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
      .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .halt_o(halt_o),
      .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) u_dut_sat (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
      .mem_redirect(mem_redirect), .ex_load(ex_load), .ex_rdest(ex_rdest),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .wb_halt(wb_halt),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
      .memwb_en(s_memwb_en), .ifid_clr(s_ifid_clr), .idex_clr(s_idex_clr),
      .exmem_clr(s_exmem_clr), .memwb_clr(s_memwb_clr), .halt_o(s_halt_o),
      .state_o(s_state_o), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   logic [4:0] w_en;
   logic [3:0] w_clr;
   assign w_en  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   assign w_clr = {ifid_clr, idex_clr, exmem_clr, memwb_clr};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Compare latch controls and state in one go
   task automatic check_ctl(input string tag, input logic [4:0] en, input logic [3:0] clr,
                            input logic [1:0] st);
      check({tag, ".en"},    32'(w_en),    32'(en));
      check({tag, ".clr"},   32'(w_clr),   32'(clr));
      check({tag, ".state"}, 32'(state_o), 32'(st));
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_dreq = 1'b0; mem_redirect = 1'b0;
      ex_load = 1'b0; ex_rdest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      id_uses_rt = 1'b0; wb_halt = 1'b0;

      // Reset holds every latch and clears counters
      @(negedge CLK); #1;
      check_ctl("rst", 5'b00000, 4'b0000, 2'b00);
      check("rst.halt",  32'(halt_o),    32'd0);
      check("rst.stall", 32'(stall_cnt), 32'd0);
      check("rst.flush", 32'(flush_cnt), 32'd0);
      RST = 1'b0; #1;
      check_ctl("run", 5'b11111, 4'b0000, 2'b00);

      // Load-use on rs
      @(negedge CLK); #1;
      check("run.stall", 32'(stall_cnt), 32'd0);
      ex_load = 1'b1; ex_rdest = 5'd5; id_rs = 5'd5; #1;
      check_ctl("lu_rs", 5'b00011, 4'b0100, 2'b00);
      @(negedge CLK);
      ex_rdest = 5'd0; id_rs = 5'd0; #1;
      check("lu_rs.stall", 32'(stall_cnt), 32'd1);
      check_ctl("lu_r0", 5'b11111, 4'b0000, 2'b00);
      // Load-use on rt only when rt is read
      @(negedge CLK);
      ex_rdest = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
      check_ctl("lu_rt", 5'b00011, 4'b0100, 2'b00);
      @(negedge CLK);
      id_uses_rt = 1'b0; #1;
      check_ctl("lu_rt_unused", 5'b11111, 4'b0000, 2'b00);
      @(negedge CLK);
      ex_load = 1'b0; #1;
      check("lu_rt.stall", 32'(stall_cnt), 32'd2);

      // Three-cycle data miss
      mem_dreq = 1'b1; dhit = 1'b0; #1;
      check_ctl("miss0", 5'b00000, 4'b0001, 2'b00);
      @(negedge CLK); #1;
      check_ctl("miss1", 5'b00000, 4'b0001, 2'b01);
      @(negedge CLK); #1;
      check_ctl("miss2", 5'b00000, 4'b0001, 2'b01);
      @(negedge CLK);
      dhit = 1'b1; #1;
      check_ctl("miss_hit", 5'b11111, 4'b0000, 2'b01);
      @(negedge CLK); #1;
      check_ctl("miss_done", 5'b11111, 4'b0000, 2'b00);
      check("miss.stall", 32'(stall_cnt), 32'd5);
      @(negedge CLK); #1;
      check("first_hit.state", 32'(state_o), 32'd0);

      // Redirect arriving under a miss is deferred to the dhit cycle
      dhit = 1'b0; mem_redirect = 1'b1; #1;
      check_ctl("redir_miss", 5'b00000, 4'b0001, 2'b00);
      @(negedge CLK);
      dhit = 1'b1; #1;
      check_ctl("redir_hit", 5'b10001, 4'b1110, 2'b01);
      @(negedge CLK); #1;
      check("redir.flush", 32'(flush_cnt), 32'd1);
      check("redir.stall", 32'(stall_cnt), 32'd6);

      // Redirect beats load-use and fetch miss
      mem_dreq = 1'b0; ex_load = 1'b1; ex_rdest = 5'd9; id_rs = 5'd9; ihit = 1'b0; #1;
      check_ctl("redir_over", 5'b10001, 4'b1110, 2'b00);
      @(negedge CLK);
      mem_redirect = 1'b0; ex_load = 1'b0; #1;
      check("redir_over.flush", 32'(flush_cnt), 32'd2);
      check_ctl("imiss", 5'b00111, 4'b1000, 2'b00);
      @(negedge CLK); #1;
      check("imiss.stall", 32'(stall_cnt), 32'd7);

      // Halt beats a simultaneous miss and redirect
      wb_halt = 1'b1; mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1; #1;
      check_ctl("halt_req", 5'b00000, 4'b0000, 2'b00);
      check("halt_req.halt", 32'(halt_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         wb_halt = 1'b0; ihit = i[0]; dhit = ~i[0]; mem_dreq = i[1]; #1;
         check_ctl("halted", 5'b00000, 4'b0000, 2'b10);
         check("halted.halt", 32'(halt_o), 32'd1);
      end
      check("halted.flush", 32'(flush_cnt), 32'd2);

      // Reset while halted returns to RUN immediately
      @(negedge CLK);
      RST = 1'b1; #1;
      check_ctl("rst_halt", 5'b00000, 4'b0000, 2'b00);
      check("rst_halt.halt",  32'(halt_o),    32'd0);
      check("rst_halt.stall", 32'(stall_cnt), 32'd0);

      // Twenty fetch-miss cycles saturate the 4-bit counter at 15
      @(negedge CLK);
      RST = 1'b0; ihit = 1'b0; dhit = 1'b1; mem_dreq = 1'b0; mem_redirect = 1'b0;
      repeat (20) @(posedge CLK);
      @(negedge CLK); #1;
      check("sat.stall16", 32'(stall_cnt),   32'd20);
      check("sat.stall4",  32'(s_stall_cnt), 32'd15);
      check("sat.flush4",  32'(s_flush_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
